// File: rtl/md_cart_bridge_if.sv
// Memory-side word port of the Mega Drive cartridge bridge.
// Ports: req/we/be/addr/wdata (master out), ack/rdata (slave out).
interface md_cart_bridge_if;
  logic        mem_req;
  logic        mem_we;
  logic [1:0]  mem_be;
  logic [20:0] mem_addr;
  logic [15:0] mem_wdata;
  logic        mem_ack;
  logic [15:0] mem_rdata;

  modport master (
    output mem_req, mem_we, mem_be,
    output mem_addr, mem_wdata,
    input  mem_ack, mem_rdata
  );

  modport slave (
    input  mem_req, mem_we, mem_be,
    input  mem_addr, mem_wdata,
    output mem_ack, mem_rdata
  );
endinterface

// File: rtl/md_cart_bridge.sv
// Cartridge strobe to req/ack memory bridge with a one-word read cache.
// Ports: MCLK, ext_reset, cart_* bus from the board, mem master port.
module md_cart_bridge #(
  parameter int          SETTLE    = 2,
  parameter logic [20:0] ADDR_MASK = 21'h1FFFFF,
  parameter bit          WRITE_EN  = 1'b0
) (
  input  logic        MCLK,
  input  logic        ext_reset,
  input  logic [20:0] cart_address,
  input  logic        cart_cs,
  input  logic        cart_oe,
  input  logic        cart_lwr,
  input  logic        cart_uwr,
  input  logic [15:0] cart_data_wr,
  output logic [15:0] cart_data,
  output logic        cart_data_en,
  md_cart_bridge_if.master mem
);

  typedef enum logic [1:0] {
    S_IDLE, S_SETTLE, S_REQ, S_HOLD
  } state_t;

  state_t      state_q, state_n;
  logic [3:0]  cnt_q, cnt_n;
  logic [20:0] a_q, a_n;
  logic        rd_q, rd_n;
  logic        wr_q, wr_n;
  logic        lwr_q, lwr_n;
  logic        uwr_q, uwr_n;
  logic [15:0] wd_q, wd_n;
  logic [20:0] c_addr_q, c_addr_n;
  logic [15:0] c_data_q, c_data_n;
  logic        c_v_q, c_v_n;
  logic [15:0] data_q, data_n;
  logic        en_q, en_n;
  logic        req_q, req_n;
  logic        we_q, we_n;
  logic [1:0]  be_q, be_n;
  logic [20:0] addr_q, addr_n;
  logic [15:0] wdata_q, wdata_n;

  logic        rd, wr, act, same, fire, hit;
  logic [20:0] addr_m;
  logic [3:0]  cnt_inc;

  assign rd     = cart_cs & cart_oe;
  assign wr     = cart_cs & (cart_lwr | cart_uwr)
                & ~cart_oe;
  assign act    = rd | wr;
  assign addr_m = cart_address & ADDR_MASK;

  // Write data only matters for stability while writing.
  assign same = (addr_m == a_q) && (rd == rd_q)
             && (wr == wr_q) && (cart_lwr == lwr_q)
             && (cart_uwr == uwr_q)
             && (!wr || cart_data_wr == wd_q);

  // Count as it will be after this edge; lets SETTLE=1
  // fire straight out of IDLE.
  assign cnt_inc = (state_q == S_SETTLE && same)
                 ? cnt_q + 4'd1 : 4'd1;
  assign fire = act && (cnt_inc == 4'(SETTLE));
  assign hit  = c_v_q && (c_addr_q == addr_m);

  always_comb begin
    state_n  = state_q;
    cnt_n    = cnt_q;
    a_n      = a_q;
    rd_n     = rd_q;
    wr_n     = wr_q;
    lwr_n    = lwr_q;
    uwr_n    = uwr_q;
    wd_n     = wd_q;
    c_addr_n = c_addr_q;
    c_data_n = c_data_q;
    c_v_n    = c_v_q;
    data_n   = data_q;
    en_n     = en_q;
    req_n    = req_q;
    we_n     = we_q;
    be_n     = be_q;
    addr_n   = addr_q;
    wdata_n  = wdata_q;
    unique case (state_q)
      S_IDLE, S_SETTLE: begin
        if (!act) begin
          state_n = S_IDLE;
          cnt_n   = 4'd0;
        end else begin
          state_n = S_SETTLE;
          cnt_n   = cnt_inc;
          a_n     = addr_m;
          rd_n    = rd;
          wr_n    = wr;
          lwr_n   = cart_lwr;
          uwr_n   = cart_uwr;
          wd_n    = cart_data_wr;
          if (fire) begin
            if (rd && hit) begin
              data_n  = c_data_q;
              en_n    = 1'b1;
              state_n = S_HOLD;
            end else if (rd) begin
              req_n   = 1'b1;
              we_n    = 1'b0;
              be_n    = 2'b11;
              addr_n  = addr_m;
              state_n = S_REQ;
            end else if (WRITE_EN) begin
              req_n   = 1'b1;
              we_n    = 1'b1;
              be_n    = {cart_uwr, cart_lwr};
              addr_n  = addr_m;
              wdata_n = cart_data_wr;
              state_n = S_REQ;
            end else begin
              state_n = S_HOLD;
            end
          end
        end
      end
      S_REQ: begin
        // Strobe drops are ignored; the bus cycle
        // always runs to its ack.
        if (mem.mem_ack) begin
          req_n = 1'b0;
          if (rd_q) begin
            c_data_n = mem.mem_rdata;
            c_addr_n = addr_q;
            c_v_n    = 1'b1;
            if (rd) begin
              data_n  = mem.mem_rdata;
              en_n    = 1'b1;
              state_n = S_HOLD;
            end else begin
              state_n = S_IDLE;
            end
          end else begin
            if (c_v_q && c_addr_q == addr_q) begin
              if (be_q[1]) c_data_n[15:8] = wdata_q[15:8];
              if (be_q[0]) c_data_n[7:0]  = wdata_q[7:0];
            end
            state_n = S_HOLD;
          end
        end
      end
      S_HOLD: begin
        if (!(rd_q ? rd : wr)) begin
          en_n    = 1'b0;
          cnt_n   = 4'd0;
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  always_ff @(posedge MCLK) begin
    if (ext_reset) begin
      state_q  <= S_IDLE;
      cnt_q    <= 4'd0;
      a_q      <= '0;
      rd_q     <= 1'b0;
      wr_q     <= 1'b0;
      lwr_q    <= 1'b0;
      uwr_q    <= 1'b0;
      wd_q     <= '0;
      c_addr_q <= '0;
      c_data_q <= '0;
      c_v_q    <= 1'b0;
      data_q   <= '0;
      en_q     <= 1'b0;
      req_q    <= 1'b0;
      we_q     <= 1'b0;
      be_q     <= 2'b00;
      addr_q   <= '0;
      wdata_q  <= '0;
    end else begin
      state_q  <= state_n;
      cnt_q    <= cnt_n;
      a_q      <= a_n;
      rd_q     <= rd_n;
      wr_q     <= wr_n;
      lwr_q    <= lwr_n;
      uwr_q    <= uwr_n;
      wd_q     <= wd_n;
      c_addr_q <= c_addr_n;
      c_data_q <= c_data_n;
      c_v_q    <= c_v_n;
      data_q   <= data_n;
      en_q     <= en_n;
      req_q    <= req_n;
      we_q     <= we_n;
      be_q     <= be_n;
      addr_q   <= addr_n;
      wdata_q  <= wdata_n;
    end
  end

  assign cart_data     = data_q;
  assign cart_data_en  = en_q;
  assign mem.mem_req   = req_q;
  assign mem.mem_we    = we_q;
  assign mem.mem_be    = be_q;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;

endmodule

// File: tb/tb_md_cart_bridge.sv
// Bench for md_cart_bridge: read/write/cache/settle/reset scenarios.
// Expected read words queue up at stimulus, popped on cart_data_en rise.
module tb_md_cart_bridge;

  logic MCLK = 1'b0;
  always #5 MCLK = ~MCLK;

  logic        ext_reset;
  logic [20:0] cart_address;
  logic        cart_cs, cart_oe, cart_lwr, cart_uwr;
  logic [15:0] cart_data_wr;
  logic [15:0] cart_data, ro_data;
  logic        cart_data_en, ro_en;

  md_cart_bridge_if m();
  md_cart_bridge_if r();

  md_cart_bridge #(
    .SETTLE(2), .ADDR_MASK(21'h1FFFFF), .WRITE_EN(1'b1)
  ) dut (
    .MCLK(MCLK), .ext_reset(ext_reset),
    .cart_address(cart_address), .cart_cs(cart_cs),
    .cart_oe(cart_oe), .cart_lwr(cart_lwr),
    .cart_uwr(cart_uwr), .cart_data_wr(cart_data_wr),
    .cart_data(cart_data), .cart_data_en(cart_data_en),
    .mem(m.master)
  );

  md_cart_bridge #(
    .SETTLE(2), .ADDR_MASK(21'h1FFFFF), .WRITE_EN(1'b0)
  ) dut_ro (
    .MCLK(MCLK), .ext_reset(ext_reset),
    .cart_address(cart_address), .cart_cs(cart_cs),
    .cart_oe(cart_oe), .cart_lwr(cart_lwr),
    .cart_uwr(cart_uwr), .cart_data_wr(cart_data_wr),
    .cart_data(ro_data), .cart_data_en(ro_en),
    .mem(r.master)
  );

  int total = 0;
  int bad = 0;
  logic [15:0] exp_q[$];
  logic [15:0] mon_e;
  logic en_prev = 1'b0;

  int nreq = 0;
  int ro_wreq = 0;
  int ack_lat = 3;
  int wcnt = 0;
  logic [15:0] rd_val = 16'h0;
  bit auto_ack = 1'b1;
  bit late_ack = 1'b0;
  logic req_prev = 1'b0;

  // Main memory: ack ack_lat negedges after req rises.
  always @(negedge MCLK) begin
    m.mem_ack = 1'b0;
    if (m.mem_req === 1'b1 && !req_prev) nreq++;
    req_prev = (m.mem_req === 1'b1);
    if (late_ack) begin
      m.mem_ack   = 1'b1;
      m.mem_rdata = 16'hDEAD;
      late_ack    = 1'b0;
    end else if (m.mem_req === 1'b1 && auto_ack) begin
      wcnt++;
      if (wcnt == ack_lat) begin
        m.mem_ack   = 1'b1;
        m.mem_rdata = rd_val;
      end
    end else begin
      wcnt = 0;
    end
  end

  // Write-protected instance: one-cycle memory.
  always @(negedge MCLK) begin
    r.mem_rdata = 16'h0000;
    r.mem_ack   = (r.mem_req === 1'b1) && !r.mem_ack;
    if (r.mem_req === 1'b1 && r.mem_we === 1'b1) ro_wreq++;
  end

  // Scoreboard: each rising en must match the oldest expected word.
  always @(posedge MCLK) begin
    #1;
    if (cart_data_en === 1'b1 && !en_prev) begin
      total++;
      if (exp_q.size() == 0) begin
        bad++;
        $display("FAIL rd_unexpected got=%h want=none", cart_data);
      end else begin
        mon_e = exp_q.pop_front();
        if (cart_data !== mon_e) begin
          bad++;
          $display("FAIL rd_data got=%h want=%h", cart_data, mon_e);
        end
      end
    end
    en_prev = (cart_data_en === 1'b1);
  end

  task step();
    @(posedge MCLK);
    #1;
  endtask

  task bus_idle();
    cart_cs  = 1'b0;
    cart_oe  = 1'b0;
    cart_lwr = 1'b0;
    cart_uwr = 1'b0;
  endtask

  task start_rd(input logic [20:0] a);
    cart_address = a;
    cart_cs  = 1'b1;
    cart_oe  = 1'b1;
    cart_lwr = 1'b0;
    cart_uwr = 1'b0;
  endtask

  task wait_en(input string nm);
    int k;
    k = 0;
    while (cart_data_en !== 1'b1 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (cart_data_en !== 1'b1) begin
      bad++;
      $display("FAIL %s en_timeout got=%b want=1", nm, cart_data_en);
    end
  endtask

  task test_reset();
    ext_reset    = 1'b1;
    cart_address = 21'h00200;
    cart_data_wr = 16'h0000;
    cart_cs  = 1'b1;
    cart_oe  = 1'b1;
    cart_lwr = 1'b1;
    cart_uwr = 1'b1;
    rd_val   = 16'h7E7E;
    ack_lat  = 2;
    repeat (3) step();
    total++;
    if ({cart_data, cart_data_en} !== 17'h0) begin
      bad++;
      $display("FAIL rst_cart got=%h/%b want=0/0", cart_data, cart_data_en);
    end
    total++;
    if ({m.mem_req, m.mem_we, m.mem_be} !== 4'h0) begin
      bad++;
      $display("FAIL rst_ctl got=%b%b%b want=0000", m.mem_req, m.mem_we, m.mem_be);
    end
    total++;
    if ({m.mem_addr, m.mem_wdata} !== 37'h0) begin
      bad++;
      $display("FAIL rst_bus got=%h/%h want=0/0", m.mem_addr, m.mem_wdata);
    end
    ext_reset = 1'b0;
    exp_q.push_back(16'h7E7E);
    step();
    total++;
    if (m.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL rst_settle1 req got=%b want=0", m.mem_req);
    end
    step();
    total++;
    if (m.mem_req !== 1'b1 || m.mem_addr !== 21'h00200) begin
      bad++;
      $display("FAIL rst_settle2 req/addr got=%b/%h want=1/00200", m.mem_req, m.mem_addr);
    end
    wait_en("rst_read");
    bus_idle();
    step();
    total++;
    if (cart_data_en !== 1'b0) begin
      bad++;
      $display("FAIL rst_drop en got=%b want=0", cart_data_en);
    end
  endtask

  task test_read_miss();
    int n0;
    n0 = nreq;
    ack_lat = 3;
    rd_val  = 16'hA55A;
    start_rd(21'h00100);
    exp_q.push_back(16'hA55A);
    step();
    total++;
    if (m.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL miss_e1 req got=%b want=0", m.mem_req);
    end
    step();
    total++;
    if ({m.mem_req, m.mem_we, m.mem_be} !== 4'b1011 || m.mem_addr !== 21'h00100) begin
      bad++;
      $display("FAIL miss_req got=%b%b%b/%h want=1011/00100", m.mem_req, m.mem_we, m.mem_be, m.mem_addr);
    end
    step();
    step();
    total++;
    if (m.mem_req !== 1'b1 || cart_data_en !== 1'b0) begin
      bad++;
      $display("FAIL miss_wait req/en got=%b/%b want=1/0", m.mem_req, cart_data_en);
    end
    step();
    total++;
    if (m.mem_req !== 1'b0 || cart_data_en !== 1'b1 || cart_data !== 16'hA55A) begin
      bad++;
      $display("FAIL miss_ack req/en/data got=%b/%b/%h want=0/1/a55a", m.mem_req, cart_data_en, cart_data);
    end
    step();
    total++;
    if (cart_data_en !== 1'b1) begin
      bad++;
      $display("FAIL miss_hold en got=%b want=1", cart_data_en);
    end
    cart_oe = 1'b0;
    step();
    total++;
    if (cart_data_en !== 1'b0 || cart_data !== 16'hA55A) begin
      bad++;
      $display("FAIL miss_drop en/data got=%b/%h want=0/a55a", cart_data_en, cart_data);
    end
    total++;
    if (nreq - n0 != 1) begin
      bad++;
      $display("FAIL miss_nreq got=%0d want=1", nreq - n0);
    end
    bus_idle();
  endtask

  task test_cache_hit();
    int n0;
    n0 = nreq;
    start_rd(21'h00100);
    exp_q.push_back(16'hA55A);
    step();
    total++;
    if (cart_data_en !== 1'b0) begin
      bad++;
      $display("FAIL hit_e1 en got=%b want=0", cart_data_en);
    end
    step();
    total++;
    if (cart_data_en !== 1'b1 || nreq != n0) begin
      bad++;
      $display("FAIL hit_e2 en/nreq got=%b/%0d want=1/%0d", cart_data_en, nreq, n0);
    end
    bus_idle();
    step();
    rd_val  = 16'h0F0F;
    ack_lat = 2;
    start_rd(21'h00101);
    exp_q.push_back(16'h0F0F);
    step();
    step();
    total++;
    if (m.mem_req !== 1'b1 || m.mem_addr !== 21'h00101) begin
      bad++;
      $display("FAIL hit_next req/addr got=%b/%h want=1/00101", m.mem_req, m.mem_addr);
    end
    wait_en("hit_next");
    bus_idle();
    step();
  endtask

  task test_settle_restart();
    int n0;
    n0 = nreq;
    rd_val  = 16'h2020;
    ack_lat = 2;
    start_rd(21'h00010);
    exp_q.push_back(16'h2020);
    step();
    cart_address = 21'h00020;
    step();
    total++;
    if (m.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL settle_restart req got=%b want=0", m.mem_req);
    end
    step();
    total++;
    if (m.mem_req !== 1'b1 || m.mem_addr !== 21'h00020) begin
      bad++;
      $display("FAIL settle_req req/addr got=%b/%h want=1/00020", m.mem_req, m.mem_addr);
    end
    wait_en("settle");
    total++;
    if (nreq - n0 != 1) begin
      bad++;
      $display("FAIL settle_nreq got=%0d want=1", nreq - n0);
    end
    bus_idle();
    step();
  endtask

  task test_write();
    int n0;
    int k;
    rd_val  = 16'hA55A;
    ack_lat = 2;
    start_rd(21'h00100);
    exp_q.push_back(16'hA55A);
    wait_en("wr_fill");
    bus_idle();
    step();
    n0 = nreq;
    cart_address = 21'h00100;
    cart_data_wr = 16'h1234;
    cart_cs  = 1'b1;
    cart_oe  = 1'b0;
    cart_uwr = 1'b1;
    cart_lwr = 1'b0;
    step();
    step();
    total++;
    if ({m.mem_req, m.mem_we, m.mem_be} !== 4'b1110 || m.mem_wdata !== 16'h1234 || m.mem_addr !== 21'h00100) begin
      bad++;
      $display("FAIL wr_req got=%b%b%b/%h/%h want=1110/1234/00100", m.mem_req, m.mem_we, m.mem_be, m.mem_wdata, m.mem_addr);
    end
    total++;
    if (r.mem_req !== 1'b0) begin
      bad++;
      $display("FAIL wr_protect req got=%b want=0", r.mem_req);
    end
    k = 0;
    while (m.mem_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (m.mem_req !== 1'b0 || cart_data_en !== 1'b0) begin
      bad++;
      $display("FAIL wr_done req/en got=%b/%b want=0/0", m.mem_req, cart_data_en);
    end
    bus_idle();
    step();
    start_rd(21'h00100);
    exp_q.push_back(16'h125A);
    step();
    step();
    total++;
    if (cart_data_en !== 1'b1 || cart_data !== 16'h125A || nreq - n0 != 1) begin
      bad++;
      $display("FAIL wr_merge en/data/nreq got=%b/%h/%0d want=1/125a/1", cart_data_en, cart_data, nreq - n0);
    end
    bus_idle();
    step();
  endtask

  task test_oe_drop();
    int n0;
    int k;
    n0 = nreq;
    rd_val  = 16'hBEEF;
    ack_lat = 4;
    start_rd(21'h00300);
    step();
    step();
    total++;
    if (m.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL drop_req got=%b want=1", m.mem_req);
    end
    cart_oe = 1'b0;
    k = 0;
    while (m.mem_req === 1'b1 && k < 20) begin
      step();
      k++;
    end
    total++;
    if (m.mem_req !== 1'b0 || cart_data_en !== 1'b0) begin
      bad++;
      $display("FAIL drop_ack req/en got=%b/%b want=0/0", m.mem_req, cart_data_en);
    end
    step();
    total++;
    if (cart_data_en !== 1'b0) begin
      bad++;
      $display("FAIL drop_after en got=%b want=0", cart_data_en);
    end
    bus_idle();
    step();
    start_rd(21'h00300);
    exp_q.push_back(16'hBEEF);
    step();
    step();
    total++;
    if (cart_data_en !== 1'b1 || nreq - n0 != 1) begin
      bad++;
      $display("FAIL drop_fill en/nreq got=%b/%0d want=1/1", cart_data_en, nreq - n0);
    end
    bus_idle();
    step();
  endtask

  task test_reset_mid_req();
    auto_ack = 1'b0;
    start_rd(21'h00400);
    step();
    step();
    total++;
    if (m.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_req got=%b want=1", m.mem_req);
    end
    step();
    ext_reset = 1'b1;
    bus_idle();
    step();
    total++;
    if (m.mem_req !== 1'b0 || cart_data_en !== 1'b0 || cart_data !== 16'h0) begin
      bad++;
      $display("FAIL rmid_rst req/en/data got=%b/%b/%h want=0/0/0000", m.mem_req, cart_data_en, cart_data);
    end
    ext_reset = 1'b0;
    step();
    late_ack = 1'b1;
    step();
    step();
    total++;
    if (m.mem_req !== 1'b0 || cart_data_en !== 1'b0 || cart_data !== 16'h0) begin
      bad++;
      $display("FAIL rmid_late req/en/data got=%b/%b/%h want=0/0/0000", m.mem_req, cart_data_en, cart_data);
    end
    auto_ack = 1'b1;
    ack_lat  = 2;
    rd_val   = 16'h3333;
    start_rd(21'h00300);
    exp_q.push_back(16'h3333);
    step();
    step();
    total++;
    if (m.mem_req !== 1'b1) begin
      bad++;
      $display("FAIL rmid_inval req got=%b want=1", m.mem_req);
    end
    wait_en("rmid_refill");
    bus_idle();
    step();
  endtask

  initial begin
    test_reset();
    test_read_miss();
    test_cache_hit();
    test_settle_restart();
    test_write();
    test_oe_drop();
    test_reset_mid_req();
    step();
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL sb_left got=%0d want=0", exp_q.size());
    end
    total++;
    if (ro_wreq != 0) begin
      bad++;
      $display("FAIL ro_writes got=%0d want=0", ro_wreq);
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/md_cart_bridge.md
Name: md_cart_bridge

Overview:
- Sits directly upstream of the Mega Drive board top and drives its cart_data / cart_data_en inputs.
- Translates the board's cartridge bus strobes (cart_cs, cart_oe, cart_lwr, cart_uwr) into a req/ack word transaction on an external memory port (SDRAM/BRAM controller).
- Holds one cached read word, so repeated 68k/Z80 reads of the same word return without a memory round-trip.

Parameters:
- SETTLE, 2: consecutive MCLK edges that strobes and address must be sampled stable before a transaction starts (1..15).
- ADDR_MASK, 21'h1FFFFF: ANDed with cart_address to form mem_addr (ROM size mirroring).
- WRITE_EN, 0: 1 = cart writes forwarded to memory; 0 = writes dropped (ROM write-protect).

Ports:
- MCLK, in, 1: system clock, same MCLK as the board.
- ext_reset, in, 1: synchronous reset, active-high.
- cart_address, in, 21: word address from the board.
- cart_cs, in, 1: chip select, active-high.
- cart_oe, in, 1: read strobe, active-high.
- cart_lwr, in, 1: low-byte write strobe, active-high.
- cart_uwr, in, 1: high-byte write strobe, active-high.
- cart_data_wr, in, 16: write data.
- cart_data, out, 16: read data to the board.
- cart_data_en, out, 1: cart_data valid; board drives VD from it.
- mem_req, out, 1: transaction request, level.
- mem_we, out, 1: 1 = write.
- mem_be, out, 2: byte enables {upper, lower}.
- mem_addr, out, 21: word address.
- mem_wdata, out, 16: write data.
- mem_ack, in, 1: single-cycle completion pulse.
- mem_rdata, in, 16: read data, valid with mem_ack.

Behaviour:
- Reset (synchronous, wins over everything):
  - cart_data=0, cart_data_en=0, mem_req=0, mem_we=0, mem_be=0, mem_addr=0, mem_wdata=0.
  - Cache invalid. FSM=IDLE. Settle counter=0.
- Decoded strobes:
  - rd = cart_cs & cart_oe.
  - wr = cart_cs & (cart_lwr | cart_uwr) & ~cart_oe.
  - rd & wr both set cannot occur by construction (the wr term excludes cart_oe), so rd takes priority.
- FSM states: IDLE, SETTLE, REQ, HOLD.
- IDLE:
  - On rd or wr: latch cart_address & ADDR_MASK and the strobe type, set count=1, go SETTLE.
  - mem_ack sampled in IDLE is ignored.
- SETTLE:
  - Each edge, if address, rd/wr, lwr/uwr (and cart_data_wr for writes) are unchanged, count increments; any change reloads the latches and sets count=1.
  - Strobe drop returns to IDLE.
  - When count==SETTLE:
    - Read hitting a valid cache with equal address: cart_data=cache, cart_data_en=1 on this edge, go HOLD. No mem_req.
    - Read miss: mem_req=1, mem_we=0, mem_be=2'b11, go REQ.
    - Write with WRITE_EN=1: mem_req=1, mem_we=1, mem_be={uwr,lwr}, mem_wdata=cart_data_wr, go REQ.
    - Write with WRITE_EN=0: go HOLD, no request.
- REQ:
  - mem_req and all mem_* outputs held constant until mem_ack.
  - On the mem_ack edge, mem_req=0.
  - Read: cache<=mem_rdata with the latched address, cache valid. If rd is still sampled high, cart_data=mem_rdata and cart_data_en=1, go HOLD; otherwise go IDLE with en left at 0.
  - Write: if the cache is valid and its address matches, merge the enabled bytes into the cache. Go HOLD.
  - A strobe drop during REQ never aborts the request; the bus cycle completes.
- HOLD:
  - cart_data_en stays 1 while rd is high.
  - On the first edge where the strobe is sampled low: cart_data_en=0, go IDLE.
  - cart_data keeps its last value after en drops.
- Latency: read miss gives en at SETTLE + (mem_ack latency) + 0 edges; read hit gives en at SETTLE edges after strobe assertion.
- mem_addr is only updated when leaving SETTLE; it does not wrap or increment.
- Reset asserted in REQ: mem_req drops the same edge; a late ack is ignored in IDLE.

Test Plan:
- Reset with all strobes high -> after reset, all outputs 0 and FSM in IDLE; release -> a request is issued only after SETTLE=2 stable edges.
- Read 0x00100 with memory ack after 3 cycles, rdata 16'hA55A -> mem_req high exactly until ack, mem_addr=0x00100; cart_data=A55A with en=1 until cart_oe falls, then en=0 the next edge.
- Repeat read of 0x00100 -> no mem_req; en=1 after 2 edges with 16'hA55A. Read of 0x00101 -> new request issued.
- Address changes from 0x10 to 0x20 after 1 stable edge -> settle restarts; a single request issued with mem_addr=0x20.
- WRITE_EN=1, write to cached 0x00100 with uwr only, data 16'h1234 -> mem_be=2'b10, mem_we=1; a subsequent read hits with 16'h125A. WRITE_EN=0 -> no mem_req at all.
- cart_oe dropped mid-REQ, then ack -> en stays 0 and cache filled; reset asserted mid-REQ -> mem_req=0 the next edge, and a later ack causes no output change.
